// File: rtl/artemis_pkg.sv
// Shared constants, FSM encodings and the EX/MEM register payload for the MEM stage.
package artemis_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned BLOCK_W       = 128;
  localparam int unsigned BEATS         = BLOCK_W / DATA_W;
  localparam int unsigned BEAT_IDX_W    = 2;
  localparam int unsigned BLOCK_ALIGN_W = 4;
  localparam int unsigned REG_W         = 5;
  localparam int unsigned L16B_W        = 2;
  localparam int unsigned STATE_W       = 3;

  localparam logic [L16B_W-1:0] L16B_NORMAL = 2'b00;
  localparam logic [L16B_W-1:0] L16B_BLOCK  = 2'b01;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_BEAT0 = 3'd1;
  localparam logic [STATE_W-1:0] ST_BEAT1 = 3'd2;
  localparam logic [STATE_W-1:0] ST_BEAT2 = 3'd3;
  localparam logic [STATE_W-1:0] ST_BEAT3 = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  reg_dest;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic [L16B_W-1:0] l16b;
    logic              block_sel;
  } exmem_t;

  function automatic logic is_beat(input logic [STATE_W-1:0] s);
    return (s >= ST_BEAT0) && (s <= ST_BEAT3);
  endfunction

endpackage

// File: rtl/block_buffer_128.sv
// Two 128-bit block buffers written one 32-bit word at a time; word 0 sits in the MSBs.
module block_buffer_128
  import artemis_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic                  sel_i,
  input  logic [BEAT_IDX_W-1:0] idx_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [BLOCK_W-1:0]    buf_a_o,
  output logic [BLOCK_W-1:0]    buf_b_o
);

  logic [BLOCK_W-1:0] buf_a_q, buf_a_d;
  logic [BLOCK_W-1:0] buf_b_q, buf_b_d;

  always_comb begin
    buf_a_d = buf_a_q;
    buf_b_d = buf_b_q;
    for (int w = 0; w < int'(BEATS); w++) begin
      if (we_i && (idx_i == BEAT_IDX_W'(w))) begin
        if (sel_i) buf_b_d[BLOCK_W-1-DATA_W*w -: DATA_W] = wdata_i;
        else       buf_a_d[BLOCK_W-1-DATA_W*w -: DATA_W] = wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_a_q <= '0;
      buf_b_q <= '0;
    end else begin
      buf_a_q <= buf_a_d;
      buf_b_q <= buf_b_d;
    end
  end

  assign buf_a_o = buf_a_q;
  assign buf_b_o = buf_b_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM register, word load/store port and the 4-beat block-load FSM.
module mem_access_stage
  import artemis_pkg::*;
(
  input  logic                Clock,
  input  logic                Reset,
  input  logic [DATA_W-1:0]   Result,
  input  logic [DATA_W-1:0]   StoreData,
  input  logic [REG_W-1:0]    RegDest_In,
  input  logic                RegWrite_In,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic                MemToReg_In,
  input  logic [L16B_W-1:0]   L16B,
  input  logic                BlockSel,
  input  logic                Flush,
  output logic [DATA_W-1:0]   DM_Addr,
  output logic [DATA_W-1:0]   DM_WriteData,
  output logic                DM_WriteEn,
  output logic                DM_ReadEn,
  input  logic [DATA_W-1:0]   DM_ReadData,
  output logic [DATA_W-1:0]   FWFromMEM,
  output logic [DATA_W-1:0]   MEM_ReadData,
  output logic [REG_W-1:0]    RegDest_Out,
  output logic                RegWrite_Out,
  output logic                MemToReg_Out,
  output logic                Stall,
  output logic [BLOCK_W-1:0]  RD1_128,
  output logic [BLOCK_W-1:0]  RD2_128,
  output logic                BlockValid
);

  exmem_t                ex_q, ex_d;
  logic [STATE_W-1:0]    state_q, state_d;
  logic                  stall_q, stall_d;
  logic                  valid_q, valid_d;
  logic [BEAT_IDX_W-1:0] beat_idx;
  logic                  word_op;

  // Accept the EX payload unless frozen; block loads never write the register file.
  always_comb begin
    ex_d = ex_q;
    if (!stall_q) begin
      ex_d.result     = Result;
      ex_d.store_data = StoreData;
      ex_d.reg_dest   = RegDest_In;
      ex_d.reg_write  = RegWrite_In && (L16B != L16B_BLOCK);
      ex_d.mem_read   = MemRead;
      ex_d.mem_write  = MemWrite;
      ex_d.mem_to_reg = MemToReg_In;
      ex_d.l16b       = L16B;
      ex_d.block_sel  = BlockSel;
      if (Flush) begin
        ex_d.reg_write = 1'b0;
        ex_d.mem_read  = 1'b0;
        ex_d.mem_write = 1'b0;
        ex_d.l16b      = L16B_NORMAL;
      end
    end
  end

  // Entering BEAT0 coincides with the block load landing in the EX/MEM register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = (ex_d.l16b == L16B_BLOCK) ? ST_BEAT0 : ST_IDLE;
      ST_BEAT0:         state_d = ST_BEAT1;
      ST_BEAT1:         state_d = ST_BEAT2;
      ST_BEAT2:         state_d = ST_BEAT3;
      ST_BEAT3:         state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
    stall_d = is_beat(state_d);
    valid_d = (state_d == ST_DONE);
  end

  always_comb begin
    beat_idx = '0;
    case (state_q)
      ST_BEAT1: beat_idx = BEAT_IDX_W'(1);
      ST_BEAT2: beat_idx = BEAT_IDX_W'(2);
      ST_BEAT3: beat_idx = BEAT_IDX_W'(3);
      default:  beat_idx = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ex_q    <= '0;
      state_q <= ST_IDLE;
      stall_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
      stall_q <= stall_d;
      valid_q <= valid_d;
    end
  end

  block_buffer_128 u_block_buffer (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .we_i    (stall_q),
    .sel_i   (ex_q.block_sel),
    .idx_i   (beat_idx),
    .wdata_i (DM_ReadData),
    .buf_a_o (RD1_128),
    .buf_b_o (RD2_128)
  );

  // SAD and block-load entries never touch the word port.
  assign word_op = (ex_q.l16b == L16B_NORMAL);

  assign DM_Addr      = stall_q
                      ? ({ex_q.result[DATA_W-1:BLOCK_ALIGN_W], BLOCK_ALIGN_W'(0)} + DATA_W'({beat_idx, 2'b00}))
                      : ex_q.result;
  assign DM_WriteData = ex_q.store_data;
  assign DM_WriteEn   = word_op && ex_q.mem_write;
  assign DM_ReadEn    = stall_q || (word_op && ex_q.mem_read);
  assign MEM_ReadData = (word_op && ex_q.mem_read) ? DM_ReadData : '0;
  assign FWFromMEM    = ex_q.result;
  assign RegDest_Out  = ex_q.reg_dest;
  assign RegWrite_Out = ex_q.reg_write;
  assign MemToReg_Out = ex_q.mem_to_reg;
  assign Stall        = stall_q;
  assign BlockValid   = valid_q;

endmodule
